rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the core's single-write-port register file. Three producers compete for the one write port: the in-order pipeline (ALU results), the load/store unit (load returns) and the multi-cycle multiply/divide unit. The arbiter grants one of them per cycle with an anti-starvation age rule and registers the winning write onto the register-file write port. An optional scoreboard tracks destinations with outstanding long-latency writes so decode can stall on RAW hazards.

---
 rtl/rf_wb_pkg.sv | 20 ++
 rtl/rf_wb_scoreboard.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
// The optional scoreboard is built when RF_WB_SCOREBOARD_EN is defined.
package rf_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int AGE_W      = 4;

  typedef enum logic [1:0] {
    REQ_PIPE,
    REQ_LSU,
    REQ_MDU
  } req_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_beat_t;

endpackage

// File: rtl/rf_wb_scoreboard.sv
// Busy vector of registers with an outstanding long-latency write, plus two
// combinational read ports for decode.
module rf_wb_scoreboard
  import rf_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_set,
  input  logic [REG_ADDR_W-1:0] i_set_addr,
  input  logic                  i_flush,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  input  logic [REG_ADDR_W-1:0] i_raddr1,
  input  logic [REG_ADDR_W-1:0] i_raddr2,
  output logic                  o_busy1,
  output logic                  o_busy2
);

  logic [2**REG_ADDR_W-1:0] r_busy;
  logic [2**REG_ADDR_W-1:0] w_busy_next;

  // Set is applied after clear so a same-edge collision leaves the bit set.
  always_comb begin
    // NOTE: start from a full default so every path assigns w_busy_next and no latch is inferred.
    w_busy_next = r_busy;
    if (i_clr) w_busy_next[i_clr_addr] = 1'b0;
    if (i_set && (i_set_addr != '0)) w_busy_next[i_set_addr] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || i_flush) r_busy <= '0;
    else                r_busy <= w_busy_next;
  end

  assign o_busy1 = r_busy[i_raddr1];
  assign o_busy2 = r_busy[i_raddr2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port: pipe > lsu > mdu
// with age promotion. Scoreboard built only when RF_WB_SCOREBOARD_EN is defined.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int AGE_MAX = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic                  lsu_valid,
  input  logic                  mdu_valid,
  output logic                  pipe_ready,
  output logic                  lsu_ready,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] pipe_waddr,
  input  logic [REG_ADDR_W-1:0] lsu_waddr,
  input  logic [REG_ADDR_W-1:0] mdu_waddr,
  input  logic [DATA_W-1:0]     pipe_wdata,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W-1:0]     mdu_wdata,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  input  logic                  sb_set,
  input  logic [REG_ADDR_W-1:0] sb_set_addr,
  input  logic                  sb_flush,
  input  logic [REG_ADDR_W-1:0] sb_raddr1,
  input  logic [REG_ADDR_W-1:0] sb_raddr2,
  output logic                  sb_busy1,
  output logic                  sb_busy2
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0]      r_lsu_age, r_mdu_age;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]     r_wdata;

  logic     w_lsu_aged, w_mdu_aged, w_accept;
  req_e     w_grant;
  wb_beat_t w_beat;

  assign w_lsu_aged = lsu_valid && (r_lsu_age == AGE_SAT);
  assign w_mdu_aged = mdu_valid && (r_mdu_age == AGE_SAT);

  // Aged requesters jump ahead of pipe; nothing is granted while in reset.
  always_comb begin
    w_accept = 1'b0;
    w_grant  = REQ_PIPE;
    if (!rst) begin
      if (w_lsu_aged)      begin w_accept = 1'b1; w_grant = REQ_LSU;  end
      else if (w_mdu_aged) begin w_accept = 1'b1; w_grant = REQ_MDU;  end
      else if (pipe_valid) begin w_accept = 1'b1; w_grant = REQ_PIPE; end
      else if (lsu_valid)  begin w_accept = 1'b1; w_grant = REQ_LSU;  end
      else if (mdu_valid)  begin w_accept = 1'b1; w_grant = REQ_MDU;  end
    end
  end

  assign pipe_ready = w_accept && (w_grant == REQ_PIPE);
  assign lsu_ready  = w_accept && (w_grant == REQ_LSU);
  assign mdu_ready  = w_accept && (w_grant == REQ_MDU);

  always_comb begin
    w_beat = '{addr: pipe_waddr, data: pipe_wdata};
    case (w_grant)
      REQ_LSU: w_beat = '{addr: lsu_waddr, data: lsu_wdata};
      REQ_MDU: w_beat = '{addr: mdu_waddr, data: mdu_wdata};
      default: w_beat = '{addr: pipe_waddr, data: pipe_wdata};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lsu_age <= '0;
      r_mdu_age <= '0;
    end else begin
      if (!lsu_valid || lsu_ready)  r_lsu_age <= '0;
      else if (r_lsu_age != AGE_SAT) r_lsu_age <= r_lsu_age + AGE_W'(1);
      if (!mdu_valid || mdu_ready)  r_mdu_age <= '0;
      else if (r_mdu_age != AGE_SAT) r_mdu_age <= r_mdu_age + AGE_W'(1);
    end
  end

  // Beats to r0 are consumed but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= (w_beat.addr != '0);
      r_waddr <= w_beat.addr;
      r_wdata <= w_beat.data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

`ifdef RF_WB_SCOREBOARD_EN
  logic w_clr;
  assign w_clr = w_accept && (w_grant != REQ_PIPE);

  rf_wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set      (sb_set),
    .i_set_addr (sb_set_addr),
    .i_flush    (sb_flush),
    .i_clr      (w_clr),
    .i_clr_addr (w_beat.addr),
    .i_raddr1   (sb_raddr1),
    .i_raddr2   (sb_raddr2),
    .o_busy1    (sb_busy1),
    .o_busy2    (sb_busy2)
  );
`else
  logic w_sb_unused;
  assign w_sb_unused = ^{sb_set, sb_set_addr, sb_flush, sb_raddr1, sb_raddr2};
  assign sb_busy1    = 1'b0;
  assign sb_busy2    = 1'b0;
`endif

endmodule
